// File: rtl/sound_scheduler.sv
// Sound-effect arbiter: grants one source at a time to the DAC sample counter,
// paces its advance strobes, and follows each sound with a silent gap.
module sound_scheduler #(
    parameter int PW          = 16,
    parameter int SW          = 8,
    parameter int PER_CRASH   = 400,
    parameter int PER_WIN     = 100,
    parameter int PER_EAT     = 200,
    parameter int STEPS_CRASH = 64,
    parameter int STEPS_WIN   = 32,
    parameter int STEPS_EAT   = 16,
    parameter int GAP_CYC     = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    output logic       at_max,
    output logic       dac_en,
    output logic [2:0] grant,
    output logic       busy,
    output logic       done
);

    localparam int GW = $clog2(GAP_CYC + 1);

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    state_t         state, state_nx;
    logic [2:0]     pending, pending_nx, grant_nx, pend_req;
    logic [PW-1:0]  per_cnt, per_cnt_nx, per_max;
    logic [SW-1:0]  step_cnt, step_cnt_nx, step_max;
    logic [GW-1:0]  gap_cnt, gap_cnt_nx;
    logic           strobe, last_step, preempt;

    // Fixed priority: crash (bit0) > win (bit1) > eat (bit2).
    function automatic logic [2:0] pick_hi(input logic [2:0] v);
        if (v[0])      return 3'b001;
        else if (v[1]) return 3'b010;
        else if (v[2]) return 3'b100;
        else           return 3'b000;
    endfunction

    always_comb begin
        case (grant)
            3'b001:  begin per_max = PW'(PER_CRASH - 1); step_max = SW'(STEPS_CRASH - 1); end
            3'b010:  begin per_max = PW'(PER_WIN - 1);   step_max = SW'(STEPS_WIN - 1);   end
            default: begin per_max = PW'(PER_EAT - 1);   step_max = SW'(STEPS_EAT - 1);   end
        endcase
    end

    always_comb begin
        pend_req  = pending | req;
        preempt   = (state == PLAY) && !grant[0] && pend_req[0];
        strobe    = (state == PLAY) && (per_cnt == per_max);
        last_step = (step_cnt == step_max);
        at_max    = strobe;
        // An aborted sound never reports completion, even on its final strobe.
        done      = strobe && last_step && !preempt;
        dac_en    = (state == PLAY);
        busy      = (state != IDLE);

        state_nx    = state;
        pending_nx  = pend_req;
        grant_nx    = grant;
        per_cnt_nx  = per_cnt;
        step_cnt_nx = step_cnt;
        gap_cnt_nx  = gap_cnt;

        case (state)
            IDLE: begin
                if (|pend_req) begin
                    grant_nx    = pick_hi(pend_req);
                    pending_nx  = pend_req & ~grant_nx;
                    per_cnt_nx  = '0;
                    step_cnt_nx = '0;
                    state_nx    = PLAY;
                end
            end
            PLAY: begin
                if (preempt) begin
                    grant_nx    = 3'b001;
                    pending_nx  = pend_req & ~(grant | 3'b001);
                    per_cnt_nx  = '0;
                    step_cnt_nx = '0;
                end else if (done) begin
                    state_nx    = GAP;
                    grant_nx    = 3'b000;
                    per_cnt_nx  = '0;
                    step_cnt_nx = '0;
                    gap_cnt_nx  = '0;
                end else if (strobe) begin
                    per_cnt_nx  = '0;
                    step_cnt_nx = step_cnt + SW'(1);
                end else begin
                    per_cnt_nx  = per_cnt + PW'(1);
                end
            end
            GAP: begin
                if (gap_cnt == GW'(GAP_CYC - 1)) begin
                    state_nx   = IDLE;
                    gap_cnt_nx = '0;
                end else begin
                    gap_cnt_nx = gap_cnt + GW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pending  <= '0;
            grant    <= '0;
            per_cnt  <= '0;
            step_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            state    <= state_nx;
            pending  <= pending_nx;
            grant    <= grant_nx;
            per_cnt  <= per_cnt_nx;
            step_cnt <= step_cnt_nx;
            gap_cnt  <= gap_cnt_nx;
        end
    end

endmodule

// File: tb/tb_sound_scheduler.sv
// Bench for sound_scheduler: directed scenarios plus random requests, all checked
// every cycle against an elapsed-time reference model of the arbiter.
module tb_sound_scheduler;

    localparam int GAP = 50;
    int PER [3] = '{400, 100, 200};
    int STP [3] = '{64, 32, 16};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] req = 3'b000;
    logic       at_max, dac_en, busy, done;
    logic [2:0] grant;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int done_seen = 0;

    // Reference model: idle / playing source m_cur for m_t cycles / silent gap.
    int       m_mode = 0;   // 0 idle, 1 playing, 2 gap
    int       m_cur  = 0;
    int       m_t    = 0;
    int       m_gap  = 0;
    bit [2:0] m_pend = 3'b000;

    sound_scheduler dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .at_max (at_max),
        .dac_en (dac_en),
        .grant  (grant),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock: apply inputs, compare outputs mid-cycle, then advance the model.
    task automatic cycle(input logic [2:0] rq, input logic rs, input bit do_chk);
        bit       pre, stb, fin;
        bit [2:0] p;
        logic [6:0] expv;
        req = rq;
        rst = rs;
        pre = 0; stb = 0; fin = 0;
        expv = 7'b0;
        if (m_mode == 1) begin
            pre  = (m_cur != 0) && (m_pend[0] || rq[0]);
            stb  = ((m_t + 1) % PER[m_cur]) == 0;
            fin  = ((m_t + 1) == PER[m_cur] * STP[m_cur]) && !pre;
            expv = {stb, 1'b1, 3'(1 << m_cur), 1'b1, fin};
        end else if (m_mode == 2) begin
            expv = 7'b0000010;
        end
        @(negedge clk);
        if (do_chk) chk($sformatf("out@%0d", cyc), {25'b0, at_max, dac_en, grant, busy, done}, {25'b0, expv});
        if (done === 1'b1) done_seen++;
        @(posedge clk);
        if (rs) begin
            m_mode = 0; m_pend = 3'b000; m_t = 0; m_gap = 0;
        end else begin
            p = m_pend | rq;
            case (m_mode)
                0: if (p != 3'b000) begin
                    m_cur = p[0] ? 0 : (p[1] ? 1 : 2);
                    p[m_cur] = 1'b0;
                    m_t = 0;
                    m_mode = 1;
                end
                1: if (pre) begin
                    p[m_cur] = 1'b0;
                    p[0] = 1'b0;
                    m_cur = 0;
                    m_t = 0;
                end else if (fin) begin
                    m_mode = 2;
                    m_gap = GAP;
                end else begin
                    m_t++;
                end
                default: begin
                    m_gap--;
                    if (m_gap == 0) m_mode = 0;
                end
            endcase
            m_pend = p;
        end
        cyc++;
        #1;
    endtask

    task automatic idle_run(input int n);
        for (int i = 0; i < n; i++) cycle(3'b000, 1'b0, 1'b1);
    endtask

    initial begin
        // 1) Reset with all requests asserted, then quiet.
        cycle(3'b111, 1'b1, 1'b0);
        cycle(3'b111, 1'b1, 1'b1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_grant", {29'b0, grant}, 32'd0);
        idle_run(5);
        chk("idle_after_rst", {31'b0, busy}, 32'd0);

        // 2) Single eat sound.
        done_seen = 0;
        cycle(3'b100, 1'b0, 1'b1);
        idle_run(16 * 200 + 50 + 5);
        chk("t2_done_cnt", done_seen, 32'd1);

        // 3) Win and eat together: win first, then eat.
        done_seen = 0;
        cycle(3'b110, 1'b0, 1'b1);
        chk("t3_first_grant", {29'b0, grant}, 32'b010);
        idle_run(32 * 100 + 50 + 16 * 200 + 50 + 5);
        chk("t3_done_cnt", done_seen, 32'd2);

        // 4) Crash pre-empts eat on eat's 5th strobe cycle.
        done_seen = 0;
        cycle(3'b100, 1'b0, 1'b1);
        idle_run(999);
        cycle(3'b001, 1'b0, 1'b1);
        chk("t4_grant_crash", {29'b0, grant}, 32'b001);
        chk("t4_no_done", done_seen, 32'd0);
        idle_run(64 * 400 + 50 + 5);
        chk("t4_done_cnt", done_seen, 32'd1);

        // 5) Eat re-requested while playing replays once.
        done_seen = 0;
        cycle(3'b100, 1'b0, 1'b1);
        idle_run(500);
        cycle(3'b100, 1'b0, 1'b1);
        idle_run(2 * (16 * 200 + 50) + 10);
        chk("t5_done_cnt", done_seen, 32'd2);

        // 6) Reset in the middle of a crash sound.
        cycle(3'b001, 1'b0, 1'b1);
        idle_run(400 * 10 + 7);
        cycle(3'b000, 1'b1, 1'b1);
        chk("t6_busy", {31'b0, busy}, 32'd0);
        chk("t6_grant", {29'b0, grant}, 32'd0);
        chk("t6_at_max", {31'b0, at_max}, 32'd0);
        idle_run(20);

        // Random requests, mostly win/eat, rare crash and reset.
        for (int i = 0; i < 12000; i++) begin
            logic [2:0] rq;
            logic       rs;
            rq[0] = ($urandom_range(0, 19999) == 0);
            rq[1] = ($urandom_range(0, 249) == 0);
            rq[2] = ($urandom_range(0, 249) == 0);
            rs    = ($urandom_range(0, 3999) == 0);
            cycle(rq, rs, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
